// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: turns halt, redirect and memory-wait
// requests into stage enables, flushes and bubbles, with a stall counter and memory timeout flag.
module pipeline_hazard_ctrl #(
  parameter int LU_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 256,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fw_halt,
  input  logic             br_redirect,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, MEM_WAIT = 2'd2} state_t;

  localparam int LU_W = $clog2(LU_STALL_CYCLES + 1) + 1;
  localparam int WT_W = $clog2(MEM_TIMEOUT + 1) + 1;
  localparam logic [LU_W-1:0] LU_MAX  = LU_W'(LU_STALL_CYCLES);
  localparam logic [WT_W-1:0] WT_LAST = WT_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [LU_W-1:0]   lu_cnt_q, lu_cnt_d;
  logic [WT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic dmem_wait, in_lu, lu_hold;

  // A MEM_WAIT entered from LU_STALL keeps lu_cnt non-zero, so the load-use
  // sequence resumes where it left off once memory responds.
  always_comb begin
    dmem_wait = dmem_req & ~dmem_ready;
    in_lu     = (state_q == LU_STALL) | ((state_q == MEM_WAIT) & (lu_cnt_q != '0));
    lu_hold   = ~dmem_wait & (in_lu ? (lu_cnt_q < LU_MAX) : fw_halt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      lu_cnt_q       <= '0;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
      mem_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      lu_cnt_q       <= lu_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      mem_timeout_q  <= mem_timeout_d;
    end
  end

  always_comb begin
    state_d    = RUN;
    lu_cnt_d   = '0;
    wait_cnt_d = '0;
    if (dmem_wait) begin
      state_d    = MEM_WAIT;
      lu_cnt_d   = lu_cnt_q;
      wait_cnt_d = (wait_cnt_q == WT_LAST) ? wait_cnt_q : wait_cnt_q + WT_W'(1);
    end else if (lu_hold) begin
      state_d  = LU_STALL;
      lu_cnt_d = in_lu ? lu_cnt_q + LU_W'(1) : LU_W'(1);
    end
    mem_timeout_d  = mem_timeout_q | (dmem_wait & (wait_cnt_d == WT_LAST));
    stall_cycles_d = stall_cycles_q;
    if (!pc_en && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    hz_state      = state_d;
    if (rst) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
      {if_id_flush, id_ex_flush, ex_mem_bubble}          = 3'b111;
      hz_state = RUN;
    end else if (dmem_wait) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
    end else if (lu_hold) begin
      {pc_en, if_id_en, id_ex_en} = 3'b000;
      ex_mem_bubble = 1'b1;
    end else if (br_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (!imem_ready) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign mem_timeout  = mem_timeout_q;

endmodule
